// File: rtl/sram_controller.sv
// Bridges 32-bit pipeline loads/stores onto a 16-bit external SRAM using two half-word
// accesses, then a fixed settle period. The pipeline is frozen (ready=0) until DONE.
module sram_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    // state | meaning
    // IDLE  | no access; latch request when wr_en|rd_en
    // LO    | low half-word access at {wa,0}
    // HI    | high half-word access at {wa,1}
    // WAIT  | three settle cycles
    // DONE  | access complete, ready=1 for one cycle
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [16:0] wa_q, wa_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic [16:0] wa_new;
    logic        wr_phase;

    // The SRAM window starts at byte 1024; addresses below it wrap silently.
    assign wa_new = 17'((address - 32'd1024) >> 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            wa_q     <= 17'd0;
            data_q   <= 32'd0;
            wr_q     <= 1'b0;
            rdata_q  <= 32'd0;
            addr_q   <= 18'd0;
            dq_out_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        data_d   = data_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_en || rd_en) begin
                    state_d = S_LO;
                    wa_d    = wa_new;
                    data_d  = writeData;
                    wr_d    = wr_en;
                    addr_d  = {wa_new, 1'b0};
                    if (wr_en) dq_out_d = writeData[15:0];
                end
            end
            S_LO: begin
                state_d = S_HI;
                addr_d  = {wa_q, 1'b1};
                if (wr_q) dq_out_d = data_q[31:16];
                else      rdata_d[15:0] = sram_dq_in;
            end
            S_HI: begin
                state_d = S_WAIT;
                cnt_d   = 2'd0;
                if (!wr_q) rdata_d[31:16] = sram_dq_in;
            end
            S_WAIT: begin
                if (cnt_q == 2'd2) state_d = S_DONE;
                else               cnt_d   = cnt_q + 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe is gated by reset so an abort suppresses the write edge in the same cycle.
    assign wr_phase    = wr_q && ((state_q == S_LO) || (state_q == S_HI)) && !reset;
    assign sram_we_n   = !wr_phase;
    assign sram_dq_oe  = wr_phase;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign readData    = rdata_q;
    assign ready       = ((state_q == S_IDLE) && !(wr_en || rd_en)) || (state_q == S_DONE);

endmodule
